// File: rtl/evo_csr_responder.sv
// evo_csr_responder: Avalon-MM CSR slave with an ID/CTRL/STATUS/ENABLE/SCRATCH/CYCLE
// register file, programmable wait states and a registered level interrupt.
module evo_csr_responder #(
  parameter int          CSR_DWIDTH  = 32,
  parameter int          CSR_AWIDTH  = 4,
  parameter int          NUM_EVT     = 8,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VAL      = 32'hc0ffee30
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CSR_AWIDTH-1:0] avs_csr_address,
  input  logic                  avs_csr_read,
  input  logic                  avs_csr_write,
  input  logic [CSR_DWIDTH-1:0] avs_csr_writedata,
  output logic                  avs_csr_waitrequest,
  output logic [CSR_DWIDTH-1:0] avs_csr_readdata,
  output logic                  avs_csr_readdatavalid,
  input  logic [NUM_EVT-1:0]    evt_i,
  output logic [CSR_DWIDTH-1:0] ctrl_o,
  output logic                  irq_o
);

  localparam logic [CSR_AWIDTH-1:0] ADDR_ID      = CSR_AWIDTH'(0);
  localparam logic [CSR_AWIDTH-1:0] ADDR_CTRL    = CSR_AWIDTH'(1);
  localparam logic [CSR_AWIDTH-1:0] ADDR_STATUS  = CSR_AWIDTH'(2);
  localparam logic [CSR_AWIDTH-1:0] ADDR_ENABLE  = CSR_AWIDTH'(3);
  localparam logic [CSR_AWIDTH-1:0] ADDR_SCRATCH = CSR_AWIDTH'(4);
  localparam logic [CSR_AWIDTH-1:0] ADDR_CYCLE   = CSR_AWIDTH'(5);
  localparam logic [3:0]            WAIT_LAST    = 4'(WAIT_STATES);

  logic [3:0]            wcnt;
  logic [CSR_DWIDTH-1:0] ctrl;
  logic [NUM_EVT-1:0]    status;
  logic [NUM_EVT-1:0]    enable;
  logic [CSR_DWIDTH-1:0] scratch;
  logic [CSR_DWIDTH-1:0] cycle;

  logic                  req;
  logic                  accept;
  logic                  wr_en;
  logic                  rd_en;
  logic [NUM_EVT-1:0]    w1c_mask;
  logic [CSR_DWIDTH-1:0] status_word;
  logic [CSR_DWIDTH-1:0] enable_word;
  logic [CSR_DWIDTH-1:0] rd_mux;

  // A request stalls until the wait counter reaches WAIT_STATES; a write wins over a read.
  assign req                 = avs_csr_read | avs_csr_write;
  assign avs_csr_waitrequest = req && (wcnt != WAIT_LAST);
  assign accept              = req && !avs_csr_waitrequest;
  assign wr_en               = accept && avs_csr_write;
  assign rd_en               = accept && avs_csr_read && !avs_csr_write;
  assign w1c_mask            = (wr_en && avs_csr_address == ADDR_STATUS)
                               ? avs_csr_writedata[NUM_EVT-1:0] : '0;
  assign ctrl_o              = ctrl;

  // Zero-extend the narrow event registers and select the read word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    status_word              = '0;
    enable_word              = '0;
    status_word[NUM_EVT-1:0] = status;
    enable_word[NUM_EVT-1:0] = enable;
    case (avs_csr_address)
      ADDR_ID:      rd_mux = CSR_DWIDTH'(ID_VAL);
      ADDR_CTRL:    rd_mux = ctrl;
      ADDR_STATUS:  rd_mux = status_word;
      ADDR_ENABLE:  rd_mux = enable_word;
      ADDR_SCRATCH: rd_mux = scratch;
      ADDR_CYCLE:   rd_mux = cycle;
      default:      rd_mux = '0;
    endcase
  end

  // Wait counter: counts stalled cycles, clears on acceptance or when the request drops.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset)                wcnt <= '0;
    else if (accept || !req)  wcnt <= '0;
    else                      wcnt <= wcnt + 4'd1;
  end

  // Read response: one-cycle strobe after acceptance, data forced to 0 otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      avs_csr_readdatavalid <= 1'b0;
      avs_csr_readdata      <= '0;
    end else begin
      avs_csr_readdatavalid <= rd_en;
      avs_csr_readdata      <= rd_en ? rd_mux : '0;
    end
  end

  // Writable registers; STATUS is sticky with event set taking priority over W1C.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl    <= '0;
      status  <= '0;
      enable  <= '0;
      scratch <= '0;
    end else begin
      status <= (status & ~w1c_mask) | evt_i;
      if (wr_en) begin
        case (avs_csr_address)
          ADDR_CTRL:    ctrl    <= avs_csr_writedata;
          ADDR_ENABLE:  enable  <= avs_csr_writedata[NUM_EVT-1:0];
          ADDR_SCRATCH: scratch <= avs_csr_writedata;
          default:      ;
        endcase
      end
    end
  end

  // Free-running cycle counter; a write to CYCLE restarts it from 0.
  always_ff @(posedge clk) begin
    if (reset)                                      cycle <= '0;
    else if (wr_en && avs_csr_address == ADDR_CYCLE) cycle <= '0;
    else                                            cycle <= cycle + 1'b1;
  end

  // Level interrupt, registered from the enabled pending events.
  always_ff @(posedge clk) begin
    if (reset) irq_o <= 1'b0;
    else       irq_o <= |(status & enable);
  end

endmodule

// File: tb/tb_evo_csr_responder.sv
// tb_evo_csr_responder: directed checks on a 3-wait-state instance and a zero-wait instance.
module tb_evo_csr_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  // 3-wait-state instance
  logic [3:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic [7:0]  evt = '0;
  logic [31:0] ctrl;
  logic        irq;

  // zero-wait instance
  logic [3:0]  z_address = '0;
  logic        z_read = 1'b0;
  logic        z_write = 1'b0;
  logic [31:0] z_writedata = '0;
  logic        z_waitrequest;
  logic [31:0] z_readdata;
  logic        z_readdatavalid;
  logic [7:0]  z_evt = '0;
  logic [31:0] z_ctrl;
  logic        z_irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  evo_csr_responder #(.WAIT_STATES(3)) dut (
    .clk(clk), .reset(reset),
    .avs_csr_address(address), .avs_csr_read(read), .avs_csr_write(write),
    .avs_csr_writedata(writedata), .avs_csr_waitrequest(waitrequest),
    .avs_csr_readdata(readdata), .avs_csr_readdatavalid(readdatavalid),
    .evt_i(evt), .ctrl_o(ctrl), .irq_o(irq)
  );

  evo_csr_responder #(.WAIT_STATES(0)) dut_z (
    .clk(clk), .reset(reset),
    .avs_csr_address(z_address), .avs_csr_read(z_read), .avs_csr_write(z_write),
    .avs_csr_writedata(z_writedata), .avs_csr_waitrequest(z_waitrequest),
    .avs_csr_readdata(z_readdata), .avs_csr_readdatavalid(z_readdatavalid),
    .evt_i(z_evt), .ctrl_o(z_ctrl), .irq_o(z_irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus access on the wait-state instance; returns just after the acceptance edge.
  task automatic access(input logic rd, input logic wr, input logic [3:0] a,
                        input logic [31:0] d, output int stalls,
                        output logic rdv, output logic [31:0] rdata);
    address = a; writedata = d; read = rd; write = wr; stalls = 0;
    #1;
    while (waitrequest && stalls < 20) begin
      @(posedge clk);
      #1;
      stalls++;
    end
    check("wait_bound", 32'(stalls < 20), 32'd1);
    @(posedge clk);
    #1;
    read = 1'b0; write = 1'b0;
    rdv = readdatavalid;
    rdata = readdata;
  endtask

  initial begin
    int          st;
    logic        v;
    logic [31:0] q;
    logic [31:0] c1;
    logic [31:0] c2;

    repeat (3) tick();
    reset = 1'b0;
    check("rst_ctrl", ctrl, 32'h0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdv", 32'(readdatavalid), 32'd0);
    check("rst_rdata", readdata, 32'h0);
    check("rst_waitreq", 32'(waitrequest), 32'd0);
    check("rst_z_rdv", 32'(z_readdatavalid), 32'd0);

    // zero-wait: read ID, then two back-to-back reads
    z_address = 4'd0; z_read = 1'b1;
    #1;
    check("z_waitreq", 32'(z_waitrequest), 32'd0);
    tick();
    check("z_id_rdv", 32'(z_readdatavalid), 32'd1);
    check("z_id_data", z_readdata, 32'hc0ffee30);
    tick();
    check("z_b2b_rdv", 32'(z_readdatavalid), 32'd1);
    z_read = 1'b0;
    tick();
    check("z_idle_rdv", 32'(z_readdatavalid), 32'd0);
    check("z_idle_rdata", z_readdata, 32'h0);

    // wait states: CTRL write and readback
    access(1'b0, 1'b1, 4'd1, 32'h0000_00A5, st, v, q);
    check("ctrl_wr_stalls", 32'(st), 32'd3);
    check("ctrl_o", ctrl, 32'h0000_00A5);
    check("ctrl_wr_no_rdv", 32'(v), 32'd0);
    access(1'b1, 1'b0, 4'd1, 32'h0, st, v, q);
    check("ctrl_rd_stalls", 32'(st), 32'd3);
    check("ctrl_rd_rdv", 32'(v), 32'd1);
    check("ctrl_rd_data", q, 32'h0000_00A5);
    tick();
    check("rdv_one_cycle", 32'(readdatavalid), 32'd0);
    check("rdata_zero_idle", readdata, 32'h0);

    // ID is read-only
    access(1'b0, 1'b1, 4'd0, 32'h1111_1111, st, v, q);
    access(1'b1, 1'b0, 4'd0, 32'h0, st, v, q);
    check("id_ro", q, 32'hc0ffee30);

    // events, enable, interrupt
    evt = 8'h05;
    tick();
    evt = 8'h00;
    access(1'b0, 1'b1, 4'd3, 32'h0000_0004, st, v, q);
    check("irq_not_yet", 32'(irq), 32'd0);
    tick();
    check("irq_set", 32'(irq), 32'd1);

    // W1C collides with a new event on the same bit: set wins
    evt = 8'h04;
    access(1'b0, 1'b1, 4'd2, 32'h0000_0004, st, v, q);
    evt = 8'h00;
    access(1'b1, 1'b0, 4'd2, 32'h0, st, v, q);
    check("status_collide", q, 32'h0000_0005);
    check("irq_held", 32'(irq), 32'd1);

    // W1C with no events clears STATUS; irq drops one cycle later
    access(1'b0, 1'b1, 4'd2, 32'h0000_0005, st, v, q);
    check("irq_lag", 32'(irq), 32'd1);
    tick();
    check("irq_clear", 32'(irq), 32'd0);
    access(1'b1, 1'b0, 4'd2, 32'h0, st, v, q);
    check("status_clear", q, 32'h0);

    // ENABLE upper bits read 0
    access(1'b0, 1'b1, 4'd3, 32'hFFFF_FF04, st, v, q);
    access(1'b1, 1'b0, 4'd3, 32'h0, st, v, q);
    check("enable_upper", q, 32'h0000_0004);

    // read+write together: write executes, no response
    access(1'b1, 1'b1, 4'd4, 32'h1234_5678, st, v, q);
    check("rw_no_rdv", 32'(v), 32'd0);
    tick();
    check("rw_no_rdv_late", 32'(readdatavalid), 32'd0);
    access(1'b1, 1'b0, 4'd4, 32'h0, st, v, q);
    check("scratch_rd", q, 32'h1234_5678);

    // CYCLE restarts on write; reads 4 cycles apart differ by 4
    access(1'b0, 1'b1, 4'd5, 32'hDEAD_BEEF, st, v, q);
    access(1'b1, 1'b0, 4'd5, 32'h0, st, v, c1);
    check("cycle_small", 32'(c1 >= 32'd1 && c1 <= 32'd7), 32'd1);
    access(1'b1, 1'b0, 4'd5, 32'h0, st, v, c2);
    check("cycle_delta", c2 - c1, 32'd4);

    // unmapped address
    access(1'b1, 1'b0, 4'd9, 32'h0, st, v, q);
    check("unmapped_rdv", 32'(v), 32'd1);
    check("unmapped_data", q, 32'h0);

    // reset while a read is stalled
    address = 4'd1; read = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; read = 1'b0;
    check("rst_stall_rdv", 32'(readdatavalid), 32'd0);
    access(1'b1, 1'b0, 4'd1, 32'h0, st, v, q);
    check("rst_ctrl_stalls", 32'(st), 32'd3);
    check("rst_ctrl_rd", q, 32'h0);

    // reset the cycle after a read is accepted
    evt = 8'h80;
    tick();
    evt = 8'h00;
    access(1'b1, 1'b0, 4'd2, 32'h0, st, v, q);
    check("pre_rst_status", q, 32'h0000_0080);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("post_rst_rdv", 32'(readdatavalid), 32'd0);
    check("post_rst_rdata", readdata, 32'h0);
    access(1'b1, 1'b0, 4'd2, 32'h0, st, v, q);
    check("post_rst_status", q, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
